hack_mem_arbiter: RTL and testbench
===================================

# hack_mem_arbiter

Shares the single-port data SPRAM between the Hack `cpu` core and one secondary requester (DMA / display / loader port). It sequences every CPU instruction into a read slot and an execute slot, and drives the CPU `hold` input to stall it. It inserts at most one DMA slot per instruction, so neither side can starve the other. It sits between `cpu` (`address_m`, `write_m`, `out_m`, `in_m`, `hold`) and the SPRAM wrapper.

## Interface
- `MEM_ADDR_WIDTH`, 14, SPRAM word-address width (16K words); CPU addresses with bit 14 set are outside SPRAM.
- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_address_m`  in  15  CPU `address_m`.
- `cpu_write_m`  in  1  CPU `write_m`.
- `cpu_out_m`  in  16  CPU `out_m` (write data).
- `cpu_hold`  out  1  to CPU `hold`; 1 freezes PC/A/D and suppresses `write_m`.
- `cpu_in_m`  out  16  to CPU `in_m`.
- `dma_req`  in  1  DMA request; held high with fields stable until `dma_ack`.
- `dma_write`  in  1  1 = write, 0 = read.
- `dma_address`  in  14  DMA word address.
- `dma_wdata`  in  16  DMA write data.
- `dma_ack`  out  1  one-cycle completion pulse.
- `dma_rdata`  out  16  read data, valid while `dma_ack`=1.
- `mem_address`  out  14  SPRAM address.
- `mem_wdata`  out  16  SPRAM write data.
- `mem_we`  out  1  SPRAM write enable.
- `mem_rdata`  in  16  SPRAM read data, one-cycle latency after address.

## Operation
- States: FETCH, EXEC, DMA. Reset forces FETCH.
- FETCH:
  - `cpu_hold`=1, `mem_address`=`cpu_address_m[13:0]`, `mem_we`=0.
  - Next state: EXEC.
- EXEC:
  - `cpu_hold`=0, `mem_address`=`cpu_address_m[13:0]`.
  - `mem_we`=`cpu_write_m & ~cpu_address_m[14]`, `mem_wdata`=`cpu_out_m`.
  - Next state: DMA if `dma_req`=1, else FETCH.
- DMA:
  - `cpu_hold`=1, `mem_address`=`dma_address`, `mem_we`=`dma_write`, `mem_wdata`=`dma_wdata`.
  - Next state: FETCH.
- `cpu_in_m` is combinational: `mem_rdata` when `cpu_address_m[14]`=0, else 16'h0000. It is meaningful only in EXEC.
- Out-of-SPRAM CPU accesses (address ≥ 16384): writes are dropped (`mem_we`=0) and reads return 0.
- `dma_ack`:
  - Registered; pulses in the cycle after the DMA state, for reads and writes alike.
  - `dma_rdata` = `mem_rdata` in that cycle.
  - The ack cycle coincides with the following FETCH.
- Requester deasserts `dma_req` on the `dma_ack` cycle or later. A request still high in the next EXEC is served as a new transfer.
- `dma_req` is sampled only in EXEC. Requests raised in FETCH/DMA wait for the next EXEC.

## Timing
- Reset values, held while `reset`=1: state FETCH, `cpu_hold`=1, `mem_we`=0, `dma_ack`=0, `dma_rdata`=0.
- `reset` overrides all states: `mem_we`=0 during any reset cycle, including reset asserted in EXEC or DMA.
- Reset asserted in DMA: the transfer is abandoned, no `dma_ack` is issued, and the requester must re-request.
- First cycle after reset release is FETCH; the CPU first advances in the second cycle (EXEC).
- CPU throughput:
  - 2 cycles/instruction with no DMA.
  - 3 cycles/instruction when DMA is serviced; back-to-back DMA still yields one EXEC every 3 cycles.
- DMA latency from `dma_req` sampled in EXEC to `dma_ack`: 2 cycles.
- SPRAM read issued in FETCH is consumed in EXEC (1-cycle latency); no bypass of an EXEC write into the following FETCH is needed (the SPRAM write completes at that edge).
- `cpu_hold` is a decode of registered state only (glitch-free; no combinational path from `dma_req`).

## Test plan
- Reset and sequencing:
  - `reset`=1 for 3 cycles -> `cpu_hold`=1, `mem_we`=0, `dma_ack`=0 throughout.
  - After release -> `cpu_hold` sequence 1,0,1,0… with `dma_req`=0.
- CPU read:
  - Stimulus: SPRAM[123]=16'h0042, `cpu_address_m`=123.
  - Response: FETCH drives `mem_address`=123; EXEC gives `cpu_in_m`=16'h0042 with `cpu_hold`=0.
- CPU write:
  - Stimulus: `cpu_address_m`=246, `cpu_write_m`=1, `cpu_out_m`=246.
  - Response: `mem_we`=1 only in EXEC; SPRAM[246]=246 afterward; `mem_we`=0 in FETCH.
- Out-of-SPRAM access:
  - `cpu_address_m`=16384 with `cpu_write_m`=1, `cpu_out_m`=16'hFFFF -> `mem_we` stays 0.
  - Read of 16384 -> `cpu_in_m`=16'h0000.
- DMA read and fairness:
  - Stimulus: SPRAM[16'h0100]=16'hBEEF; `dma_req`=1, `dma_write`=0, `dma_address`=16'h0100 held continuously.
  - Response: `dma_ack` pulses every 3 cycles with `dma_rdata`=16'hBEEF; `cpu_hold`=0 exactly once per 3 cycles.
  - A DMA write of 16'h1234 to 16'h0200 lands in SPRAM.
- Reset mid-DMA:
  - Stimulus: `reset` asserted during the DMA state of a write to 16'h0300 (SPRAM preset 16'h0000).
  - Response: no `dma_ack`, SPRAM[16'h0300] remains 16'h0000, state FETCH on release.

Source files
------------

// File: rtl/hack_mem_arbiter.sv
// hack_mem_arbiter: shares the single-port data SPRAM between the Hack CPU and
// one secondary requester (DMA / display / loader). Each CPU instruction gets a
// FETCH (read) slot and an EXEC slot. At most one DMA slot is inserted after each
// EXEC, so neither side can starve the other.
module hack_mem_arbiter #(
    parameter int unsigned MEM_ADDR_WIDTH = 14
) (
    input  logic                      clock,
    input  logic                      reset,
    // CPU side
    input  logic [MEM_ADDR_WIDTH:0]   cpu_address_m,
    input  logic                      cpu_write_m,
    input  logic [15:0]               cpu_out_m,
    output logic                      cpu_hold,
    output logic [15:0]               cpu_in_m,
    // Secondary requester side
    input  logic                      dma_req,
    input  logic                      dma_write,
    input  logic [MEM_ADDR_WIDTH-1:0] dma_address,
    input  logic [15:0]               dma_wdata,
    output logic                      dma_ack,
    output logic [15:0]               dma_rdata,
    // SPRAM side
    output logic [MEM_ADDR_WIDTH-1:0] mem_address,
    output logic [15:0]               mem_wdata,
    output logic                      mem_we,
    input  logic [15:0]               mem_rdata
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_DMA   = 2'd2
    } state_e;

    state_e state_q;
    logic   dma_ack_q;

    // CPU addresses with the top bit set fall outside the SPRAM.
    logic cpu_in_spram;
    assign cpu_in_spram = ~cpu_address_m[MEM_ADDR_WIDTH];

    // Slot sequencer and registered DMA completion pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            dma_ack_q <= 1'b0;
        end else begin
            dma_ack_q <= (state_q == ST_DMA);
            case (state_q)
                ST_FETCH: state_q <= ST_EXEC;
                ST_EXEC:  state_q <= dma_req ? ST_DMA : ST_FETCH;
                ST_DMA:   state_q <= ST_FETCH;
                default:  state_q <= ST_FETCH;
            endcase
        end
    end

    // SPRAM port steering; reset always blocks writes, whatever the state.
    always_comb begin
        mem_address = cpu_address_m[MEM_ADDR_WIDTH-1:0];
        mem_wdata   = cpu_out_m;
        mem_we      = 1'b0;
        case (state_q)
            ST_EXEC: begin
                mem_we = cpu_write_m & cpu_in_spram;
            end
            ST_DMA: begin
                mem_address = dma_address;
                mem_wdata   = dma_wdata;
                mem_we      = dma_write;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    // Hold is a pure state decode; reset forces it high even before the first edge.
    assign cpu_hold  = reset | (state_q != ST_EXEC);

    // Read data reaches the CPU combinationally; out-of-SPRAM reads return zero.
    assign cpu_in_m  = cpu_in_spram ? mem_rdata : 16'h0000;

    // The ack cycle is the one in which the DMA-slot read data arrives.
    assign dma_ack   = dma_ack_q & ~reset;
    assign dma_rdata = dma_ack ? mem_rdata : 16'h0000;

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Directed bench for hack_mem_arbiter with a behavioural 1-cycle-latency SPRAM.
module tb_hack_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [14:0] cpu_address_m;
    logic        cpu_write_m;
    logic [15:0] cpu_out_m;
    logic        cpu_hold;
    logic [15:0] cpu_in_m;
    logic        dma_req;
    logic        dma_write;
    logic [13:0] dma_address;
    logic [15:0] dma_wdata;
    logic        dma_ack;
    logic [15:0] dma_rdata;
    logic [13:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;

    logic [15:0] spram [0:16383];

    int n_total = 0;
    int n_pass  = 0;

    hack_mem_arbiter #(.MEM_ADDR_WIDTH(14)) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_address_m (cpu_address_m),
        .cpu_write_m   (cpu_write_m),
        .cpu_out_m     (cpu_out_m),
        .cpu_hold      (cpu_hold),
        .cpu_in_m      (cpu_in_m),
        .dma_req       (dma_req),
        .dma_write     (dma_write),
        .dma_address   (dma_address),
        .dma_wdata     (dma_wdata),
        .dma_ack       (dma_ack),
        .dma_rdata     (dma_rdata),
        .mem_address   (mem_address),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_rdata     (mem_rdata)
    );

    always #5 clock = ~clock;

    // Single-port SPRAM: registered read of the presented address, write at the edge.
    always @(posedge clock) begin
        if (mem_we) spram[mem_address] <= mem_wdata;
        mem_rdata <= spram[mem_address];
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) spram[i] = 16'h0000;
        spram[0]       = 16'h5555;
        spram[123]     = 16'h0042;
        spram[14'h100] = 16'hBEEF;

        reset = 1'b1; cpu_address_m = '0; cpu_write_m = 1'b0; cpu_out_m = '0;
        dma_req = 1'b0; dma_write = 1'b0; dma_address = '0; dma_wdata = '0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("rst_hold", 32'(cpu_hold), 32'd1);
            chk("rst_we",   32'(mem_we),   32'd0);
            chk("rst_ack",  32'(dma_ack),  32'd0);
        end

        // Release: FETCH, EXEC, FETCH, EXEC
        reset = 1'b0; #1;
        chk("seq0_hold", 32'(cpu_hold), 32'd1);
        cyc(); #1; chk("seq1_hold", 32'(cpu_hold), 32'd0);
        cyc(); #1; chk("seq2_hold", 32'(cpu_hold), 32'd1);
        cyc(); #1; chk("seq3_hold", 32'(cpu_hold), 32'd0);

        // CPU read of 123
        cyc(); cpu_address_m = 15'd123; #1;
        chk("rd_fetch_addr", 32'(mem_address), 32'd123);
        chk("rd_fetch_hold", 32'(cpu_hold), 32'd1);
        chk("rd_fetch_we",   32'(mem_we), 32'd0);
        cyc(); #1;
        chk("rd_exec_hold", 32'(cpu_hold), 32'd0);
        chk("rd_exec_data", 32'(cpu_in_m), 32'h0042);

        // CPU write of 246 to 246
        cyc(); cpu_address_m = 15'd246; cpu_write_m = 1'b1; cpu_out_m = 16'd246; #1;
        chk("wr_fetch_we", 32'(mem_we), 32'd0);
        cyc(); #1;
        chk("wr_exec_we",    32'(mem_we), 32'd1);
        chk("wr_exec_addr",  32'(mem_address), 32'd246);
        chk("wr_exec_wdata", 32'(mem_wdata), 32'd246);
        cyc();
        // Out-of-SPRAM write of FFFF to 16384 (maps to word 0 if not blocked)
        cpu_address_m = 15'd16384; cpu_out_m = 16'hFFFF; #1;
        chk("wr_landed",  32'(spram[246]), 32'd246);
        chk("oob_fetch_we", 32'(mem_we), 32'd0);
        cyc(); #1;
        chk("oob_exec_hold", 32'(cpu_hold), 32'd0);
        chk("oob_exec_we",   32'(mem_we), 32'd0);
        chk("oob_exec_rd",   32'(cpu_in_m), 32'h0000);
        cyc(); cpu_write_m = 1'b0; cpu_address_m = 15'd0; #1;
        chk("oob_word0_kept", 32'(spram[0]), 32'h5555);

        // Continuous DMA read of 0x100: ack every third cycle
        dma_req = 1'b1; dma_write = 1'b0; dma_address = 14'h100;
        for (int k = 0; k < 2; k++) begin
            cyc(); #1;
            chk("dmar_exec_hold", 32'(cpu_hold), 32'd0);
            chk("dmar_exec_ack",  32'(dma_ack), 32'd0);
            cyc(); #1;
            chk("dmar_slot_hold", 32'(cpu_hold), 32'd1);
            chk("dmar_slot_addr", 32'(mem_address), 32'h100);
            chk("dmar_slot_we",   32'(mem_we), 32'd0);
            chk("dmar_slot_ack",  32'(dma_ack), 32'd0);
            cyc(); #1;
            chk("dmar_ack",       32'(dma_ack), 32'd1);
            chk("dmar_rdata",     32'(dma_rdata), 32'hBEEF);
            chk("dmar_ack_hold",  32'(cpu_hold), 32'd1);
        end

        // DMA write 0x1234 to 0x200, issued on the previous ack cycle
        dma_write = 1'b1; dma_address = 14'h200; dma_wdata = 16'h1234;
        cyc(); #1;
        chk("dmaw_exec_hold", 32'(cpu_hold), 32'd0);
        cyc(); #1;
        chk("dmaw_slot_we",    32'(mem_we), 32'd1);
        chk("dmaw_slot_addr",  32'(mem_address), 32'h200);
        chk("dmaw_slot_wdata", 32'(mem_wdata), 32'h1234);
        cyc(); dma_req = 1'b0; #1;
        chk("dmaw_ack",    32'(dma_ack), 32'd1);
        chk("dmaw_landed", 32'(spram[14'h200]), 32'h1234);
        cyc(); #1;
        chk("dmaw_exec2_ack",  32'(dma_ack), 32'd0);
        chk("dmaw_exec2_hold", 32'(cpu_hold), 32'd0);
        cyc(); #1;
        chk("idle_fetch_hold", 32'(cpu_hold), 32'd1);

        // Reset during the DMA slot of a write to 0x300
        dma_req = 1'b1; dma_write = 1'b1; dma_address = 14'h300; dma_wdata = 16'hABCD;
        cyc(); #1;
        chk("rdma_exec_hold", 32'(cpu_hold), 32'd0);
        cyc(); reset = 1'b1; #1;
        chk("rdma_slot_we",   32'(mem_we), 32'd0);
        chk("rdma_slot_hold", 32'(cpu_hold), 32'd1);
        cyc(); reset = 1'b0; dma_req = 1'b0; #1;
        chk("rdma_no_ack",   32'(dma_ack), 32'd0);
        chk("rdma_fetch",    32'(cpu_hold), 32'd1);
        chk("rdma_mem_kept", 32'(spram[14'h300]), 32'h0000);
        cyc(); #1;
        chk("rdma_exec_hold2", 32'(cpu_hold), 32'd0);
        chk("rdma_exec_ack",   32'(dma_ack), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
